vita49_tsgen: RTL
=================

# vita49_tsgen

Parametrised VITA-49 timestamp generator for one sample-clock domain. It keeps an integer-seconds counter (TSI) and a fractional sample counter (TSF) that wraps at a programmable samples-per-second period. It can arm on an external PPS/sync edge to load both counters, and can re-align to every later sync edge. It replaces the fixed two-channel free-running TSF counter and drives the packetiser timestamp fields plus a coherent processor snapshot.

## Interface
- TSF_W, 64, fractional counter width
- TSI_W, 32, integer-seconds counter width
- NSYNC, 2, number of external sync inputs
- SHIFT_W, 3, width of runtime decimation shift (shift range 0..2^SHIFT_W-1)

- samp_clk  in  1  sample clock; the only clock
- ARESETN  in  1  asynchronous, active-low reset
- sync  in  NSYNC  asynchronous sync/PPS inputs
- sync_mask  in  NSYNC  sync inputs ORed into the sync source
- en  in  1  run enable (level)
- clr  in  1  clear request (level)
- arm  in  1  arm request (level, sampled in IDLE only)
- resync_en  in  1  re-align on sync edges while RUN
- tsf_period  in  TSF_W  TSF wrap value (samples per second); 0 = free-run, no TSI increment
- tsi_load, tsf_load  in  TSI_W / TSF_W  values loaded on the armed sync edge
- shift  in  SHIFT_W  right shift applied to TSF on output
- snap_req  in  1  single-cycle snapshot request
- tsi, tsf  out  TSI_W / TSF_W  live timestamp (tsf = count >> shift)
- tsi_snap, tsf_snap  out  TSI_W / TSF_W  snapshot registers
- snap_valid  out  1  snapshot captured since last clr
- state  out  2  FSM state
- sync_err  out  1  sticky: resync edge arrived misaligned
- load_err  out  1  sticky: tsf_load > tsf_period (period ≠ 0)

## Operation
- FSM states: IDLE, ARMED, RUN.
  - IDLE: counters hold. arm=1 → ARMED; else en=1 → RUN.
  - ARMED: counters hold. On a sync edge: tsi_cnt←tsi_load, tsf_cnt←tsf_load → RUN. en=0 → IDLE.
  - RUN: counting. en=0 → IDLE, counts held.
- clr has top priority in every state: FSM → IDLE; counters, snapshots, snap_valid, sync_err and load_err all ← 0.
- Counting, period ≠ 0: when tsf_cnt ≥ tsf_period, tsf_cnt←0 and tsi_cnt←tsi_cnt+1; otherwise tsf_cnt←tsf_cnt+1. tsi_cnt wraps modulo 2^TSI_W.
- Counting, period = 0: tsf_cnt increments modulo 2^TSF_W; tsi_cnt holds.
- Load check: if tsf_load > tsf_period and period ≠ 0, load 0 instead of tsf_load and set load_err.
- Resync (RUN, resync_en=1, period ≠ 0) on a sync edge:
  - tsf_cnt == tsf_period: aligned, count normally.
  - otherwise: tsf_cnt←0, tsi_cnt←tsi_cnt+1, set sync_err.
  - With period = 0, resync is ignored.
- Sync source = |(sync & sync_mask). It passes a 2-FF synchronizer; the edge is sync_r & ~sync_rr.
- snap_req: tsi_snap/tsf_snap ← current tsi/tsf outputs; snap_valid←1. If snap_req and clr occur together, clr wins.

## Timing
- Reset values: all outputs 0; state = IDLE.
- Sync latency: input high before edge k → sync_r=1 at k → edge detected in cycle k..k+1 → counters loaded at edge k+1 → tsi/tsf outputs show the load value after edge k+2.
- tsi/tsf outputs are registered: one cycle behind the counters. The shift is applied in that register stage.
- Snapshot: captured at the snap_req edge; visible, with snap_valid, on the next cycle.
- Held level sync produces exactly one edge. A new edge requires sync low for ≥2 cycles.
- Priority within one cycle: clr > state transition/load > resync > count.

## Structure
- Package vita49_tsgen_pkg holds:
  - state encodings: IDLE=2'd0, ARMED=2'd1, RUN=2'd2
  - default parameter constants
- Sub-module vita49_sync_edge: 2-FF synchronizer plus rising-edge detect, async active-low reset, one output pulse per edge.

## Test plan
- Free-run: period=0, en=1 for 10 cycles, shift=1 → tsf output steps 0,0,1,1,2…; tsi stays 0.
- Wrap: period=4, en=1 → tsf 0,1,2,3,4,0…; tsi increments every 5 cycles; tsi=2^TSI_W-1 rolls to 0.
- Armed load: arm=1, tsi_load=7, tsf_load=2, pulse sync[1] with mask=2'b10 → state ARMED→RUN; outputs 7/2 after edge k+2; sync[0] alone ignored.
- Resync: period=9, RUN, sync edge at tsf_cnt=5 → tsf→0, tsi+1, sync_err=1; an aligned edge leaves sync_err unchanged.
- Load error: period=4, tsf_load=6 → loaded 0, load_err=1; clr clears it and returns to IDLE.
- Reset/clr mid-RUN: assert ARESETN low, or clr, mid-count → all outputs 0 and IDLE within 0 cycles (async) / 1 cycle (clr); snap_req with clr → snap_valid stays 0.

Source files
------------

// File: rtl/vita49_tsgen_pkg.sv
// Shared state encodings and default sizing for the VITA-49 timestamp generator.
package vita49_tsgen_pkg;

    localparam int TSF_W_DEF   = 64;
    localparam int TSI_W_DEF   = 32;
    localparam int NSYNC_DEF   = 2;
    localparam int SHIFT_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } tsgen_state_t;

endpackage

// File: rtl/vita49_sync_edge.sv
// Two-flop synchronizer for the combined sync source with a one-cycle rising-edge pulse.
module vita49_sync_edge (
    input  logic samp_clk,
    input  logic ARESETN,
    input  logic sync_src,
    output logic sync_pulse
);

    logic sync_r_reg;
    logic sync_rr_reg;

    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            sync_r_reg  <= 1'b0;
            sync_rr_reg <= 1'b0;
        end else begin
            sync_r_reg  <= sync_src;
            sync_rr_reg <= sync_r_reg;
        end
    end

    assign sync_pulse = sync_r_reg & ~sync_rr_reg;

endmodule

// File: rtl/vita49_tsgen.sv
// VITA-49 integer/fractional timestamp generator with sync-armed load, resync and snapshot.
module vita49_tsgen
    import vita49_tsgen_pkg::*;
#(
    parameter int TSF_W   = TSF_W_DEF,
    parameter int TSI_W   = TSI_W_DEF,
    parameter int NSYNC   = NSYNC_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic               samp_clk,
    input  logic               ARESETN,
    input  logic [NSYNC-1:0]   sync,
    input  logic [NSYNC-1:0]   sync_mask,
    input  logic               en,
    input  logic               clr,
    input  logic               arm,
    input  logic               resync_en,
    input  logic [TSF_W-1:0]   tsf_period,
    input  logic [TSI_W-1:0]   tsi_load,
    input  logic [TSF_W-1:0]   tsf_load,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               snap_req,
    output logic [TSI_W-1:0]   tsi,
    output logic [TSF_W-1:0]   tsf,
    output logic [TSI_W-1:0]   tsi_snap,
    output logic [TSF_W-1:0]   tsf_snap,
    output logic               snap_valid,
    output logic [1:0]         state,
    output logic               sync_err,
    output logic               load_err
);

    localparam logic [TSI_W-1:0] TSI_ONE = {{(TSI_W-1){1'b0}}, 1'b1};
    localparam logic [TSF_W-1:0] TSF_ONE = {{(TSF_W-1){1'b0}}, 1'b1};

    logic [NSYNC-1:0] sync_gated;
    logic             sync_src;
    logic             sync_edge;
    logic             period_zero;
    logic             load_bad;

    tsgen_state_t     state_reg;
    logic [TSI_W-1:0] tsi_cnt_reg;
    logic [TSF_W-1:0] tsf_cnt_reg;
    logic [TSI_W-1:0] tsi_reg;
    logic [TSF_W-1:0] tsf_reg;
    logic [TSI_W-1:0] tsi_snap_reg;
    logic [TSF_W-1:0] tsf_snap_reg;
    logic             snap_valid_reg;
    logic             sync_err_reg;
    logic             load_err_reg;

    generate
        for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync_mask
            assign sync_gated[gi] = sync[gi] & sync_mask[gi];
        end
    endgenerate

    assign sync_src = |sync_gated;

    vita49_sync_edge u_sync_edge (
        .samp_clk   (samp_clk),
        .ARESETN    (ARESETN),
        .sync_src   (sync_src),
        .sync_pulse (sync_edge)
    );

    assign period_zero = (tsf_period == '0);
    assign load_bad    = !period_zero && (tsf_load > tsf_period);

    // Control FSM and the timestamp counters; clr outranks every transition.
    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg    <= ST_IDLE;
            tsi_cnt_reg  <= '0;
            tsf_cnt_reg  <= '0;
            sync_err_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else if (clr) begin
            state_reg    <= ST_IDLE;
            tsi_cnt_reg  <= '0;
            tsf_cnt_reg  <= '0;
            sync_err_reg <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arm) begin
                        state_reg <= ST_ARMED;
                    end else if (en) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (sync_edge) begin
                        state_reg   <= ST_RUN;
                        tsi_cnt_reg <= tsi_load;
                        if (load_bad) begin
                            tsf_cnt_reg  <= '0;
                            load_err_reg <= 1'b1;
                        end else begin
                            tsf_cnt_reg <= tsf_load;
                        end
                    end else if (!en) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_reg <= ST_IDLE;
                    end else if (period_zero) begin
                        tsf_cnt_reg <= tsf_cnt_reg + TSF_ONE;
                    end else if (resync_en && sync_edge && (tsf_cnt_reg != tsf_period)) begin
                        // Misaligned PPS: force the second boundary now.
                        tsf_cnt_reg  <= '0;
                        tsi_cnt_reg  <= tsi_cnt_reg + TSI_ONE;
                        sync_err_reg <= 1'b1;
                    end else if (tsf_cnt_reg >= tsf_period) begin
                        tsf_cnt_reg <= '0;
                        tsi_cnt_reg <= tsi_cnt_reg + TSI_ONE;
                    end else begin
                        tsf_cnt_reg <= tsf_cnt_reg + TSF_ONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Output stage: shifted live timestamp plus a snapshot of that same stage.
    always_ff @(posedge samp_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            tsi_reg        <= '0;
            tsf_reg        <= '0;
            tsi_snap_reg   <= '0;
            tsf_snap_reg   <= '0;
            snap_valid_reg <= 1'b0;
        end else if (clr) begin
            tsi_reg        <= '0;
            tsf_reg        <= '0;
            tsi_snap_reg   <= '0;
            tsf_snap_reg   <= '0;
            snap_valid_reg <= 1'b0;
        end else begin
            tsi_reg <= tsi_cnt_reg;
            tsf_reg <= tsf_cnt_reg >> shift;
            if (snap_req) begin
                tsi_snap_reg   <= tsi_reg;
                tsf_snap_reg   <= tsf_reg;
                snap_valid_reg <= 1'b1;
            end
        end
    end

    assign tsi        = tsi_reg;
    assign tsf        = tsf_reg;
    assign tsi_snap   = tsi_snap_reg;
    assign tsf_snap   = tsf_snap_reg;
    assign snap_valid = snap_valid_reg;
    assign state      = state_reg;
    assign sync_err   = sync_err_reg;
    assign load_err   = load_err_reg;

endmodule
